// File: rtl/regfile_multi.sv
// regfile_multi
//   General-purpose register file: NRD combinational read ports, one
//   synchronous write port, register 0 hardwired to zero. A soft-clear
//   request (Init) starts a sweep that zeroes registers 1..DEPTH-1, one per
//   cycle. CLR is an asynchronous, active-high hard reset.
//
//   Optional build macro: REGFILE_BYPASS_EN
//     When defined, a read port whose address matches an active write
//     (nonzero address, not Busy) returns WriteData in the same cycle.
//
// Ports
//   CK            clock, all state changes on posedge
//   CLR           asynchronous active-high reset
//   Init          soft-clear request, sampled on posedge
//   ReadRegster   NRD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   ReadData      NRD packed read data,      port k at [k*DATA_W +: DATA_W]
//   RegWrite      write enable
//   WriteRegster  write address
//   WriteData     write data
//   Busy          sweep in progress
//   Done          one-cycle pulse after the sweep completes
//   WrDrop        one-cycle pulse: a write was discarded during a sweep
module regfile_multi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                   CK,
  input  logic                   CLR,
  input  logic                   Init,
  input  logic [NRD*ADDR_W-1:0]  ReadRegster,
  output logic [NRD*DATA_W-1:0]  ReadData,
  input  logic                   RegWrite,
  input  logic [ADDR_W-1:0]      WriteRegster,
  input  logic [DATA_W-1:0]      WriteData,
  output logic                   Busy,
  output logic                   Done,
  output logic                   WrDrop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} stateT;

  stateT             state, stateNext;
  logic [ADDR_W-1:0] ptr, ptrNext;
  logic              wrEn;
  logic              sweepEnd;
  logic              dropNow;
  logic [DATA_W-1:0] regs [DEPTH];

  // Next-state / control decode
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    wrEn      = 1'b0;
    sweepEnd  = 1'b0;
    dropNow   = 1'b0;
    case (state)
      IDLE: begin
        // A write in the same cycle as Init still lands; the sweep erases it.
        wrEn = RegWrite && (WriteRegster != '0);
        if (Init) begin
          stateNext = SWEEP;
          ptrNext   = PTR_FIRST;
        end
      end
      SWEEP: begin
        dropNow = RegWrite && (WriteRegster != '0);
        ptrNext = ptr + ADDR_W'(1);
        if (ptr == PTR_LAST) begin
          sweepEnd  = 1'b1;
          stateNext = IDLE;
          ptrNext   = PTR_FIRST;
        end
      end
      default: begin
        stateNext = IDLE;
        ptrNext   = PTR_FIRST;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      ptr    <= PTR_FIRST;
      Done   <= 1'b0;
      WrDrop <= 1'b0;
    end else begin
      state  <= stateNext;
      ptr    <= ptrNext;
      Done   <= sweepEnd;
      WrDrop <= dropNow;
    end
  end

  // Register array: hard reset, writeback, sweep clear
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[WriteRegster] <= WriteData;
    end else if (state == SWEEP) begin
      regs[ptr] <= '0;
    end
  end

  assign Busy = (state == SWEEP);

  // Combinational read ports
  for (genvar k = 0; k < NRD; k++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = ReadRegster[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      if (!Busy && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (WriteRegster == addr)) data = WriteData;
        else                                    data = regs[addr];
`else
        data = regs[addr];
`endif
      end
    end

    assign ReadData[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_multi.sv
module tb_regfile_multi;

  logic        CK = 1'b0;
  logic        CLR;
  logic        Init;
  logic [9:0]  ReadRegster;
  logic [63:0] ReadData;
  logic        RegWrite;
  logic [4:0]  WriteRegster;
  logic [31:0] WriteData;
  logic        Busy, Done, WrDrop;

  // Narrow instance: NRD=4, ADDR_W=3, DATA_W=16
  logic        sInit;
  logic [11:0] sReadRegster;
  logic [63:0] sReadData;
  logic        sRegWrite;
  logic [2:0]  sWriteRegster;
  logic [15:0] sWriteData;
  logic        sBusy, sDone, sWrDrop;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  regfile_multi #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .CK(CK), .CLR(CLR), .Init(Init),
    .ReadRegster(ReadRegster), .ReadData(ReadData),
    .RegWrite(RegWrite), .WriteRegster(WriteRegster), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .WrDrop(WrDrop)
  );

  regfile_multi #(.DATA_W(16), .ADDR_W(3), .NRD(4)) dutSmall (
    .CK(CK), .CLR(CLR), .Init(sInit),
    .ReadRegster(sReadRegster), .ReadData(sReadData),
    .RegWrite(sRegWrite), .WriteRegster(sWriteRegster), .WriteData(sWriteData),
    .Busy(sBusy), .Done(sDone), .WrDrop(sWrDrop)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        expDrop;
  } vecT;

  vecT vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busyCnt, doneCnt, dropCnt, doneAt, dropAt, nzBusy, nzAfter;
    logic [31:0] expBypass;

    vecs[0] = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd0, 32'h12345678, 32'h00000000, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd3,  5'd0, 32'h12345678, 32'h00000000, 1'b0};
    vecs[2] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd3, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd5, 32'h80000001, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b0, 5'd6,  32'h11111111, 5'd6,  5'd31, 32'h00000000, 32'h80000001, 1'b0};
    vecs[5] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd6, 32'hA5A5A5A5, 32'h00000000, 1'b0};

    CLR = 1'b1; Init = 1'b0; RegWrite = 1'b0; WriteRegster = '0; WriteData = '0;
    ReadRegster = {5'd5, 5'd3};
    sInit = 1'b0; sRegWrite = 1'b0; sWriteRegster = '0; sWriteData = '0; sReadRegster = '0;

    // Reset state
    #12;
    chk("rst_busy",   64'(Busy),   64'd0);
    chk("rst_done",   64'(Done),   64'd0);
    chk("rst_wrdrop", 64'(WrDrop), 64'd0);
    chk("rst_rdata",  ReadData,    64'd0);
    CLR = 1'b0;
    step();

    // Table-driven writes and reads
    for (int i = 0; i < 6; i++) begin
      RegWrite     = vecs[i].we;
      WriteRegster = vecs[i].wa;
      WriteData    = vecs[i].wd;
      ReadRegster  = {vecs[i].ra1, vecs[i].ra0};
      step();
      RegWrite = 1'b0;
      #3;
      chk($sformatf("vec%0d_rd0", i), 64'(ReadData[31:0]),  64'(vecs[i].exp0));
      chk($sformatf("vec%0d_rd1", i), 64'(ReadData[63:32]), 64'(vecs[i].exp1));
      chk($sformatf("vec%0d_drop", i), 64'(WrDrop), 64'(vecs[i].expDrop));
    end

    // Asynchronous reset between clock edges
    ReadRegster = {5'd3, 5'd5};
    #1;
    chk("preclr_r5", 64'(ReadData[31:0]),  64'h00000000DEADBEEF);
    chk("preclr_r3", 64'(ReadData[63:32]), 64'h00000000A5A5A5A5);
    #1 CLR = 1'b1;
    #1;
    chk("clr_r5",   64'(ReadData[31:0]),  64'd0);
    chk("clr_r3",   64'(ReadData[63:32]), 64'd0);
    chk("clr_busy", 64'(Busy), 64'd0);
    #1 CLR = 1'b0;
    step();

    // Fill registers 1..31 with their own index
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteRegster = 5'(i); WriteData = 32'(i);
      step();
    end
    RegWrite = 1'b0;
    ReadRegster = {5'd31, 5'd7};
    #1;
    chk("fill_r7",  64'(ReadData[31:0]),  64'd7);
    chk("fill_r31", 64'(ReadData[63:32]), 64'd31);

    // Sweep with a dropped write and an ignored Init
    Init = 1'b1;
    step();
    Init = 1'b0;
    busyCnt = 0; doneCnt = 0; dropCnt = 0; doneAt = -1; dropAt = -1; nzBusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (Busy) begin
        busyCnt++;
        if (ReadData != 64'd0) nzBusy++;
      end
      if (Done)   begin doneCnt++; doneAt = c; end
      if (WrDrop) begin dropCnt++; dropAt = c; end
      RegWrite = (c == 2);
      WriteRegster = 5'd7; WriteData = 32'hAAAA5555;
      Init = (c == 5);
      step();
    end
    RegWrite = 1'b0; Init = 1'b0;
    chk("sweep_busy_cycles", 64'(busyCnt), 64'd31);
    chk("sweep_reads_zero",  64'(nzBusy),  64'd0);
    chk("sweep_done_count",  64'(doneCnt), 64'd1);
    chk("sweep_done_cycle",  64'(doneAt),  64'd31);
    chk("sweep_drop_count",  64'(dropCnt), 64'd1);
    chk("sweep_drop_cycle",  64'(dropAt),  64'd3);

    nzAfter = 0;
    for (int i = 1; i < 32; i++) begin
      ReadRegster = {5'(i), 5'(i)};
      step();
      if (ReadData != 64'd0) nzAfter++;
    end
    chk("after_sweep_nonzero", 64'(nzAfter), 64'd0);
    ReadRegster = {5'd0, 5'd7};
    #1;
    chk("after_sweep_r7", 64'(ReadData[31:0]), 64'd0);

    // Same-cycle write and read of register 9
`ifdef REGFILE_BYPASS_EN
    expBypass = 32'hCAFEF00D;
`else
    expBypass = 32'h00000000;
`endif
    ReadRegster = {5'd0, 5'd9};
    RegWrite = 1'b1; WriteRegster = 5'd9; WriteData = 32'hCAFEF00D;
    #1;
    chk("same_cycle_r9", 64'(ReadData[31:0]), 64'(expBypass));
    step();
    RegWrite = 1'b0;
    #1;
    chk("after_edge_r9", 64'(ReadData[31:0]), 64'h00000000CAFEF00D);
    chk("r9_wrdrop",     64'(WrDrop), 64'd0);

    // Narrow instance: four simultaneous reads, then a 7-cycle sweep
    for (int i = 1; i < 8; i++) begin
      sRegWrite = 1'b1; sWriteRegster = 3'(i); sWriteData = 16'h1000 + 16'(i) * 16'h0111;
      step();
    end
    sRegWrite = 1'b0;
    sReadRegster = {3'd1, 3'd4, 3'd6, 3'd7};
    #1;
    chk("small_4reads", sReadData, {16'h1111, 16'h1444, 16'h1666, 16'h1777});

    sInit = 1'b1;
    step();
    sInit = 1'b0;
    busyCnt = 0; doneCnt = 0; doneAt = -1;
    for (int c = 0; c < 12; c++) begin
      if (sBusy) busyCnt++;
      if (sDone) begin doneCnt++; doneAt = c; end
      step();
    end
    chk("small_busy_cycles", 64'(busyCnt), 64'd7);
    chk("small_done_count",  64'(doneCnt), 64'd1);
    chk("small_done_cycle",  64'(doneAt),  64'd7);
    chk("small_after_sweep", sReadData, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
